sha_stream_padder: RTL

- Generalised SHA-2 message padder for multi-block messages of arbitrary whole-word length.
- Accepts a word stream with valid/ready/last and emits the padded stream in 16-word blocks: message words, pad marker, zero fill and a two-word bit-length field.
- Emits an extra block whenever the length field does not fit.
- Sits between the message source (hash-of-hash feedback or external data) and the message-schedule/compression core.
- Supports SHA-256 (WORD_W=32) and SHA-512 (WORD_W=64) framing.

---
 rtl/sha_stream_padder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sha_stream_padder.sv
// SHA-2 message padder: frames a word stream into 16-word blocks with
// pad marker, zero fill and a two-word bit-length trailer.
module sha_stream_padder #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] msg_word,
    input  logic              msg_valid,
    input  logic              msg_last,
    output logic              msg_ready,
    output logic [WORD_W-1:0] word_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_block_last,
    output logic              out_msg_last,
    output logic              busy
);

    localparam int LEN_W = 2 * WORD_W;
    localparam int SH = $clog2(WORD_W);
    localparam logic [WORD_W-1:0] MARKER = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, DATA, PAD, ZERO_WRAP, ZERO, LEN_HI, LEN_LO
    } state_t;

    state_t state, state_n;
    logic [3:0] slot, slot_n;
    logic [CNT_W-1:0] count, count_n;
    logic [WORD_W-1:0] word_n, data;
    logic valid_n, first_n, blast_n, mlast_n;
    logic load, emit;
    logic [LEN_W-1:0] bitlen;

    assign load = !out_valid || out_ready;
    assign msg_ready = (state == DATA) && load;
    assign busy = (state != IDLE);
    assign bitlen = LEN_W'(count) << SH;

    // slot is the block position of the next word loaded into word_o
    always_comb begin
        state_n = state;
        slot_n = slot;
        count_n = count;
        word_n = word_o;
        valid_n = out_valid;
        first_n = out_first;
        blast_n = out_block_last;
        mlast_n = out_msg_last;
        emit = 1'b0;
        data = '0;
        if (load) begin
            valid_n = 1'b0;
            first_n = 1'b0;
            blast_n = 1'b0;
            mlast_n = 1'b0;
        end
        unique case (state)
            IDLE: begin
                count_n = '0;
                slot_n = '0;
                if (load) state_n = DATA;
            end
            DATA: begin
                if (msg_valid && load) begin
                    emit = 1'b1;
                    data = msg_word;
                    count_n = count + CNT_ONE;
                    if (msg_last) state_n = PAD;
                end
            end
            PAD: begin
                if (load) begin
                    emit = 1'b1;
                    data = MARKER;
                    if (slot == 4'd13) state_n = LEN_HI;
                    else if (slot == 4'd14) state_n = ZERO_WRAP;
                    else state_n = ZERO;
                end
            end
            ZERO_WRAP: begin
                if (load) begin
                    emit = 1'b1;
                    if (slot == 4'd15) state_n = ZERO;
                end
            end
            ZERO: begin
                if (load) begin
                    emit = 1'b1;
                    if (slot == 4'd13) state_n = LEN_HI;
                end
            end
            LEN_HI: begin
                if (load) begin
                    emit = 1'b1;
                    data = bitlen[LEN_W-1:WORD_W];
                    state_n = LEN_LO;
                end
            end
            LEN_LO: begin
                if (load) begin
                    emit = 1'b1;
                    data = bitlen[WORD_W-1:0];
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (emit) begin
            word_n = data;
            valid_n = 1'b1;
            first_n = (slot == 4'd0);
            blast_n = (slot == 4'd15);
            mlast_n = (state == LEN_LO);
            slot_n = slot + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            slot <= '0;
            count <= '0;
            word_o <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_block_last <= 1'b0;
            out_msg_last <= 1'b0;
        end else begin
            state <= state_n;
            slot <= slot_n;
            count <= count_n;
            word_o <= word_n;
            out_valid <= valid_n;
            out_first <= first_n;
            out_block_last <= blast_n;
            out_msg_last <= mlast_n;
        end
    end

endmodule
